// File: rtl/eight_by_eight_sad.sv
// Six-stage pipelined 8x8 sum-of-absolute-differences engine, 5-cycle latency.
// Define SAD_ZERO_FLAG_EN to add the pipeline-aligned sad_zero output.
module eight_by_eight_sad (
  input  logic         clk,
  input  logic         aclr_n,
  input  logic [511:0] xpixels,
  input  logic [511:0] ypixels,
`ifdef SAD_ZERO_FLAG_EN
  output logic         sad_zero,
`endif
  output logic [13:0]  sad
);

  logic [511:0]      x_q, x_d;
  logic [511:0]      y_q, y_d;
  logic [63:0][7:0]  ad_q, ad_d;
  logic [15:0][9:0]  s3_q, s3_d;
  logic [3:0][11:0]  s4_q, s4_d;
  logic [1:0][12:0]  s5_q, s5_d;
  logic [13:0]       sad_q, sad_d;
`ifdef SAD_ZERO_FLAG_EN
  logic              zero_q, zero_d;
`endif

  always_comb begin
    x_d = xpixels;
    y_d = ypixels;

    ad_d = '0;
    for (int i = 0; i < 64; i++) begin
      if (x_q[8*i +: 8] >= y_q[8*i +: 8])
        ad_d[i] = x_q[8*i +: 8] - y_q[8*i +: 8];
      else
        ad_d[i] = y_q[8*i +: 8] - x_q[8*i +: 8];
    end

    // Every adder tree level grows by the bits its fan-in needs.
    s3_d = '0;
    for (int i = 0; i < 16; i++)
      s3_d[i] = 10'(ad_q[4*i])   + 10'(ad_q[4*i+1])
              + 10'(ad_q[4*i+2]) + 10'(ad_q[4*i+3]);

    s4_d = '0;
    for (int i = 0; i < 4; i++)
      s4_d[i] = 12'(s3_q[4*i])   + 12'(s3_q[4*i+1])
              + 12'(s3_q[4*i+2]) + 12'(s3_q[4*i+3]);

    s5_d = '0;
    for (int i = 0; i < 2; i++)
      s5_d[i] = 13'(s4_q[2*i]) + 13'(s4_q[2*i+1]);

    sad_d = 14'(s5_q[0]) + 14'(s5_q[1]);
`ifdef SAD_ZERO_FLAG_EN
    zero_d = (sad_d == 14'd0);
`endif
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      x_q    <= '0;
      y_q    <= '0;
      ad_q   <= '0;
      s3_q   <= '0;
      s4_q   <= '0;
      s5_q   <= '0;
      sad_q  <= '0;
`ifdef SAD_ZERO_FLAG_EN
      zero_q <= 1'b1;
`endif
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      ad_q   <= ad_d;
      s3_q   <= s3_d;
      s4_q   <= s4_d;
      s5_q   <= s5_d;
      sad_q  <= sad_d;
`ifdef SAD_ZERO_FLAG_EN
      zero_q <= zero_d;
`endif
    end
  end

  assign sad = sad_q;
`ifdef SAD_ZERO_FLAG_EN
  assign sad_zero = zero_q;
`endif

endmodule

// File: tb/tb_eight_by_eight_sad.sv
// Directed-vector and random bench for eight_by_eight_sad.
// Checks sad (and sad_zero when SAD_ZERO_FLAG_EN is defined).
module tb_eight_by_eight_sad;

  logic         clk = 1'b0;
  logic         aclr_n;
  logic [511:0] xp, yp;
  logic [13:0]  sad;
`ifdef SAD_ZERO_FLAG_EN
  logic         sad_zero;
`endif

  always #5 clk = ~clk;

  eight_by_eight_sad dut (
    .clk     (clk),
    .aclr_n  (aclr_n),
    .xpixels (xp),
    .ypixels (yp),
`ifdef SAD_ZERO_FLAG_EN
    .sad_zero(sad_zero),
`endif
    .sad     (sad)
  );

  typedef struct {
    logic [511:0] x;
    logic [511:0] y;
    logic [13:0]  exp;
  } vec_t;

  vec_t         vecs [0:9];
  int           n_chk = 0;
  int           n_fail = 0;
  logic [13:0]  hist [0:5];

  function automatic logic [13:0] model(input logic [511:0] x,
                                        input logic [511:0] y);
    int s, a, b;
    s = 0;
    for (int i = 0; i < 64; i++) begin
      a = int'(x[8*i +: 8]);
      b = int'(y[8*i +: 8]);
      s += (a > b) ? a - b : b - a;
    end
    return 14'(s);
  endfunction

  task automatic check(input string nm, input logic [13:0] exp);
    n_chk++;
    if (sad !== exp) begin
      n_fail++;
      $display("FAIL %s: sad=%0d expected %0d at %0t", nm, sad, exp, $time);
    end
`ifdef SAD_ZERO_FLAG_EN
    n_chk++;
    if (sad_zero !== (exp == 14'd0)) begin
      n_fail++;
      $display("FAIL %s_zero: sad_zero=%0b expected %0b at %0t",
               nm, sad_zero, (exp == 14'd0), $time);
    end
`endif
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 6; i++) hist[i] = 14'd0;
  endtask

  task automatic step(input string nm, input logic [511:0] x,
                      input logic [511:0] y, input logic [13:0] e);
    xp = x;
    yp = y;
    @(posedge clk);
    for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = e;
    #1;
    check(nm, hist[5]);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [511:0] t, rx, ry;

    vecs[0] = '{x: '0, y: {64{8'hFF}}, exp: 14'd16320};
    vecs[1] = '{x: {64{8'hFF}}, y: '0, exp: 14'd16320};
    t = '0;
    t[8*37 +: 8] = 8'h80;
    vecs[2] = '{x: t, y: {64{8'h05}}, exp: 14'd438};
    vecs[3] = '{x: {64{8'hA5}}, y: {64{8'hA5}}, exp: 14'd0};
    vecs[4] = '{x: {{63{8'h33}}, 8'h10}, y: {{63{8'h33}}, 8'h00}, exp: 14'd16};
    vecs[5] = '{x: {64{8'h40}}, y: {8'h41, {63{8'h40}}}, exp: 14'd1};
    vecs[6] = '{x: {64{8'h01}}, y: '0, exp: 14'd64};
    vecs[7] = '{x: {32{8'hFF, 8'h00}}, y: {32{8'h00, 8'hFF}}, exp: 14'd16320};
    vecs[8] = '{x: {64{8'h80}}, y: {64{8'h7F}}, exp: 14'd64};
    vecs[9] = '{x: {64{8'hC8}}, y: {64{8'h64}}, exp: 14'd6400};

    aclr_n = 1'b0;
    xp = {64{8'hFF}};
    yp = '0;
    clear_hist();
    #1;
    check("reset_state", 14'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_clk", 14'd0);
    @(negedge clk);
    aclr_n = 1'b1;

    // First five steps must show the flushed zeros.
    for (int i = 0; i < 10; i++) step("vector", vecs[i].x, vecs[i].y, vecs[i].exp);
    for (int i = 0; i < 6; i++) step("drain", vecs[3].x, vecs[3].y, 14'd0);

    // Held-constant input: result appears on the sixth edge.
    clear_hist();
    for (int i = 0; i < 5; i++) step("const_fill", '0, {64{8'hFF}}, 14'd16320);
    step("const_sixth", '0, {64{8'hFF}}, 14'd16320);
    n_chk++;
    if (sad !== 14'h3FC0) begin
      n_fail++;
      $display("FAIL const_max: sad=%0h expected 3fc0", sad);
    end

    // Back-to-back 0 then 16.
    step("stream_eq", {64{8'h5A}}, {64{8'h5A}}, 14'd0);
    step("stream_d16", {{63{8'h5A}}, 8'h10}, {{63{8'h5A}}, 8'h00}, 14'd16);
    for (int i = 0; i < 6; i++) step("stream_drain", '0, '0, 14'd0);

    for (int i = 0; i < 10000; i++) begin
      rx = rnd512();
      ry = (i % 97 == 0) ? rx : rnd512();
      step("random", rx, ry, model(rx, ry));
    end

    // Asynchronous reset between edges with the pipeline full.
    #3;
    aclr_n = 1'b0;
    #1;
    check("rst_async", 14'd0);
    clear_hist();
    repeat (2) begin
      xp = rnd512();
      yp = rnd512();
      @(posedge clk);
      #1;
      check("rst_held", 14'd0);
    end
    @(negedge clk);
    aclr_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx = rnd512();
      ry = rnd512();
      step("refill", rx, ry, model(rx, ry));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
